// File: rtl/crc_pkg.sv
// Shared types, preset CRC variants and bit-reversal helpers
// for the parametrised CRC engine.
package crc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } crc_state_t;

  typedef struct packed {
    logic [31:0] poly;
    logic [31:0] init;
    logic [31:0] xor_out;
    logic        refl_in;
    logic        refl_out;
  } crc_preset_t;

  localparam crc_preset_t CRC16_XMODEM = '{
    poly: 32'h0000_1021, init: 32'h0,
    xor_out: 32'h0, refl_in: 1'b0, refl_out: 1'b0
  };

  localparam crc_preset_t CRC16_CCITT_FALSE = '{
    poly: 32'h0000_1021, init: 32'h0000_FFFF,
    xor_out: 32'h0, refl_in: 1'b0, refl_out: 1'b0
  };

  localparam crc_preset_t CRC32 = '{
    poly: 32'h04C1_1DB7, init: 32'hFFFF_FFFF,
    xor_out: 32'hFFFF_FFFF, refl_in: 1'b1, refl_out: 1'b1
  };

  function automatic logic [7:0] reflect8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  // Reverses the low n bits of v; bits at and above n come back zero.
  function automatic logic [31:0] reverse_n(
    input logic [31:0] v,
    input int          n
  );
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i] = v[n-1-i];
    return r;
  endfunction

endpackage

// File: rtl/crc_step.sv
// Combinational Galois LFSR advance by BITS data bits,
// MSB of data_i consumed first.
module crc_step
  import crc_pkg::*;
#(
  parameter int               CRC_W = 16,
  parameter logic [CRC_W-1:0] POLY  = 16'h1021,
  parameter int               BITS  = 1
) (
  input  logic [CRC_W-1:0] lfsr_i,
  input  logic [BITS-1:0]  data_i,
  output logic [CRC_W-1:0] lfsr_o
);

  logic [CRC_W-1:0] ch [BITS+1];

  assign ch[0] = lfsr_i;

  for (genvar k = 0; k < BITS; k++) begin : g_bit
    logic fb;
    assign fb = data_i[BITS-1-k] ^ ch[k][CRC_W-1];
    assign ch[k+1] = {ch[k][CRC_W-2:0], 1'b0}
                   ^ (fb ? POLY : '0);
  end

  assign lfsr_o = ch[BITS];

endmodule

// File: rtl/crc_engine.sv
// Streaming CRC generator: accumulates over multi-word messages
// and hands the final CRC out on a valid/ready port.
module crc_engine
  import crc_pkg::*;
#(
  parameter int               CRC_W        = 16,
  parameter logic [CRC_W-1:0] POLY         = 16'h1021,
  parameter logic [CRC_W-1:0] INIT         = '0,
  parameter logic [CRC_W-1:0] XOR_OUT      = '0,
  parameter int               DATA_W       = 24,
  parameter int               BITS_PER_CYC = 1,
  parameter bit               REFLECT_IN   = 1'b0,
  parameter bit               REFLECT_OUT  = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_first,
  input  logic              in_last,
  output logic              crc_valid,
  input  logic              crc_ready,
  output logic [CRC_W-1:0]  crc_out,
  output logic              busy
);

  localparam int N  = DATA_W / BITS_PER_CYC;
  localparam int CW = $clog2(N) + 1;

  crc_state_t        state_q;
  logic [CRC_W-1:0]  lfsr_q;
  logic [CRC_W-1:0]  lfsr_d;
  logic [CRC_W-1:0]  crc_q;
  logic [CRC_W-1:0]  res_d;
  logic [DATA_W-1:0] sh_q;
  logic [DATA_W-1:0] din;
  logic [CW-1:0]     cnt_q;
  logic              last_q;

  if (REFLECT_IN) begin : g_rin
    for (genvar b = 0; b < DATA_W / 8; b++) begin : g_byte
      assign din[8*b +: 8] = reflect8(in_data[8*b +: 8]);
    end
  end else begin : g_nrin
    assign din = in_data;
  end

  crc_step #(
    .CRC_W (CRC_W),
    .POLY  (POLY),
    .BITS  (BITS_PER_CYC)
  ) u_step (
    .lfsr_i (lfsr_q),
    .data_i (sh_q[DATA_W-1 -: BITS_PER_CYC]),
    .lfsr_o (lfsr_d)
  );

  assign res_d = (REFLECT_OUT
               ? CRC_W'(reverse_n(32'(lfsr_d), CRC_W))
               : lfsr_d) ^ XOR_OUT;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lfsr_q  <= INIT;
      crc_q   <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            sh_q    <= din;
            last_q  <= in_last;
            cnt_q   <= '0;
            state_q <= SHIFT;
            if (in_first) lfsr_q <= INIT;
          end
        end
        SHIFT: begin
          lfsr_q <= lfsr_d;
          sh_q   <= sh_q << BITS_PER_CYC;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == CW'(N - 1)) begin
            if (last_q) begin
              crc_q   <= res_d;
              state_q <= DONE;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        DONE: begin
          if (crc_ready) begin
            lfsr_q  <= INIT;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign crc_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign crc_out   = crc_q;

endmodule

// File: tb/tb_crc_engine.sv
// Directed bench: XMODEM, CCITT-FALSE (8 bits/cycle) and CRC-32
// instances driven from a vector table plus corner sequences.
module tb_crc_engine;
  import crc_pkg::*;

  typedef struct {
    int          u;
    logic [23:0] w;
    logic        f;
    logic        l;
    logic [31:0] exp;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [23:0] in_data;
  logic        in_first;
  logic        in_last;
  logic        crc_ready;
  logic [2:0]  vld;
  logic [2:0]  rdy;
  logic [2:0]  cv;
  logic [2:0]  bsy;
  logic [15:0] crc_a;
  logic [15:0] crc_b;
  logic [31:0] crc_c;
  logic [31:0] co [3];

  int nvec = 0;
  int nerr = 0;
  int spc [3] = '{25, 4, 9};
  vec_t tbl [$];

  assign co[0] = {16'h0, crc_a};
  assign co[1] = {16'h0, crc_b};
  assign co[2] = crc_c;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  crc_engine u_a (
    .clk (clk), .rst (rst),
    .in_valid (vld[0]), .in_ready (rdy[0]),
    .in_data (in_data), .in_first (in_first),
    .in_last (in_last), .crc_valid (cv[0]),
    .crc_ready (crc_ready), .crc_out (crc_a),
    .busy (bsy[0])
  );

  crc_engine #(
    .INIT (CRC16_CCITT_FALSE.init[15:0]),
    .BITS_PER_CYC (8)
  ) u_b (
    .clk (clk), .rst (rst),
    .in_valid (vld[1]), .in_ready (rdy[1]),
    .in_data (in_data), .in_first (in_first),
    .in_last (in_last), .crc_valid (cv[1]),
    .crc_ready (crc_ready), .crc_out (crc_b),
    .busy (bsy[1])
  );

  crc_engine #(
    .CRC_W (32),
    .POLY (CRC32.poly),
    .INIT (CRC32.init),
    .XOR_OUT (CRC32.xor_out),
    .DATA_W (8),
    .BITS_PER_CYC (1),
    .REFLECT_IN (1'b1),
    .REFLECT_OUT (1'b1)
  ) u_c (
    .clk (clk), .rst (rst),
    .in_valid (vld[2]), .in_ready (rdy[2]),
    .in_data (in_data[7:0]), .in_first (in_first),
    .in_last (in_last), .crc_valid (cv[2]),
    .crc_ready (crc_ready), .crc_out (crc_c),
    .busy (bsy[2])
  );

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic send(
    input  int          u,
    input  logic [23:0] w,
    input  logic        f,
    input  logic        l,
    output time         ta
  );
    int n;
    n = 0;
    @(negedge clk);
    in_data  = w;
    in_first = f;
    in_last  = l;
    vld[u]   = 1'b1;
    while (!rdy[u] && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("accept_timeout", 32'(n), 0);
    @(posedge clk);
    ta = $time;
    #1 vld[u] = 1'b0;
  endtask

  task automatic get(
    input int          u,
    input logic [31:0] exp,
    input int          lat,
    input string       nm
  );
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!cv[u] && k < 300);
    chk({nm, "_lat"}, 32'(k), 32'(lat));
    chk({nm, "_crc"}, co[u], exp);
    crc_ready = 1'b1;
    @(negedge clk);
    crc_ready = 1'b0;
    chk({nm, "_done1"}, {31'h0, cv[u]}, 0);
    chk({nm, "_hold"}, co[u], exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    time ta;
    time tp;
    int  k;
    tp = 0;

    tbl.push_back('{1, 24'h313233, 1'b1, 1'b0, 32'h0});
    tbl.push_back('{1, 24'h343536, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{1, 24'h373839, 1'b0, 1'b1, 32'h29B1});
    for (int b = 0; b < 9; b++)
      tbl.push_back('{2, 24'(8'h31 + b), b == 0, b == 8,
                      32'hCBF43926});
    tbl.push_back('{0, 24'h313233, 1'b1, 1'b0, 32'h0});
    tbl.push_back('{0, 24'h343536, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{0, 24'h373839, 1'b0, 1'b1, 32'h31C3});
    tbl.push_back('{0, 24'h313233, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{0, 24'h343536, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{0, 24'h373839, 1'b0, 1'b1, 32'h31C3});

    rst       = 1'b1;
    vld       = '0;
    in_data   = '0;
    in_first  = 1'b0;
    in_last   = 1'b0;
    crc_ready = 1'b0;
    #1;
    chk("rst_crc_out", crc_c, 0);
    chk("rst_valid", {29'h0, cv}, 0);
    chk("rst_busy", {29'h0, bsy}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 chk("rst_ready", {29'h0, rdy}, 32'h7);

    for (int i = 0; i < tbl.size(); i++) begin
      send(tbl[i].u, tbl[i].w, tbl[i].f, tbl[i].l, ta);
      if (i > 0 && tbl[i-1].u == tbl[i].u && !tbl[i-1].l)
        chk("spacing", 32'((ta - tp) / 10), 32'(spc[tbl[i].u]));
      tp = ta;
      if (tbl[i].l)
        get(tbl[i].u, tbl[i].exp, spc[tbl[i].u], "tbl");
    end

    // Reset mid-SHIFT, then a message with no in_first.
    send(0, 24'h313233, 1'b1, 1'b0, ta);
    repeat (5) @(negedge clk);
    chk("busy_shift", {31'h0, bsy[0]}, 1);
    chk("ready_shift", {31'h0, rdy[0]}, 0);
    rst = 1'b1;
    #1;
    chk("midrst_crc", co[0], 0);
    chk("midrst_valid", {31'h0, cv[0]}, 0);
    chk("midrst_busy", {31'h0, bsy[0]}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 chk("midrst_ready", {31'h0, rdy[0]}, 1);
    send(0, 24'h313233, 1'b0, 1'b0, ta);
    send(0, 24'h343536, 1'b0, 1'b0, ta);
    send(0, 24'h373839, 1'b0, 1'b1, ta);
    get(0, 32'h31C3, 25, "postrst");

    // Backpressure with stray in_valid pulses during DONE.
    send(0, 24'h313233, 1'b1, 1'b0, ta);
    send(0, 24'h343536, 1'b0, 1'b0, ta);
    send(0, 24'h373839, 1'b0, 1'b1, ta);
    k = 0;
    while (!cv[0] && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("bp_valid", {31'h0, cv[0]}, 1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 3) begin
        in_data  = 24'hFFFFFF;
        in_first = 1'b1;
        in_last  = 1'b1;
        vld[0]   = 1'b1;
      end
      if (c == 6) vld[0] = 1'b0;
      chk("bp_hold", {14'h0, cv[0], rdy[0], crc_a},
          {14'h0, 1'b1, 1'b0, 16'h31C3});
    end
    vld[0]    = 1'b0;
    crc_ready = 1'b1;
    @(negedge clk);
    crc_ready = 1'b0;
    chk("bp_release", {30'h0, cv[0], rdy[0]}, 32'h1);
    chk("bp_keep", co[0], 32'h31C3);
    send(0, 24'h000000, 1'b1, 1'b1, ta);
    get(0, 32'h0000, 25, "zero");

    // in_first mid-message discards the partial CRC.
    send(0, 24'h313233, 1'b1, 1'b0, ta);
    send(0, 24'h313233, 1'b1, 1'b0, ta);
    send(0, 24'h343536, 1'b0, 1'b0, ta);
    send(0, 24'h373839, 1'b0, 1'b1, ta);
    get(0, 32'h31C3, 25, "restart");

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
